// File: rtl/pla_sop_pipe.sv
// -----------------------------------------------------------------------------
// pla_sop_pipe
//   Two-stage pipelined, runtime-programmable sum-of-products evaluator.
//   All lanes are evaluated against one shared cube table. Each lane yields a
//   complementary pair: a positive output gated by the lane's enable field and
//   a negative output gated by its inverse.
//
//   Configuration is double-buffered. cfg_we writes one shadow entry, and
//   cfg_commit copies the whole shadow table into the active table. Only
//   stage 1 reads the active table, so a commit never corrupts a sample that
//   is already in flight.
//
//   Optional feature macro: PLA_SOP_STATS_EN. When it is defined, the stat_cnt
//   port and its saturating counter are added.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_valid     upstream sample offered
//   in_ready     upstream sample accepted when in_valid & in_ready
//   in_data      LANES*FIELDS bits; field f of lane l is at bit f*LANES+l
//   out_valid    result present
//   out_ready    downstream accepts the result
//   out_z        bit l = positive output of lane l,
//                bit LANES+l = negative output of lane l
//   cfg_we       write one shadow entry {cfg_tv, cfg_pol, cfg_care, cfg_val}
//   cfg_addr     shadow entry index; a value >= TERMS is ignored
//   cfg_care     per-field care mask
//   cfg_val      per-field required value
//   cfg_pol      0 = term feeds the positive OR, 1 = term feeds the negative OR
//   cfg_tv       term valid
//   cfg_commit   copy the shadow table to the active table
//   stat_cnt     (PLA_SOP_STATS_EN only) count of output handshakes that
//                carry any positive bit; saturates, cleared by commit
// -----------------------------------------------------------------------------
module pla_sop_pipe #(
  parameter int LANES    = 8,
  parameter int FIELDS   = 16,
  parameter int TERMS    = 8,
  parameter int EN_FIELD = 5,
  localparam int AW      = $clog2(TERMS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*FIELDS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*LANES-1:0]      out_z,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [FIELDS-1:0]       cfg_care,
  input  logic [FIELDS-1:0]       cfg_val,
  input  logic                    cfg_pol,
  input  logic                    cfg_tv,
  input  logic                    cfg_commit
`ifdef PLA_SOP_STATS_EN
  ,
  output logic [15:0]             stat_cnt
`endif
);

  typedef struct packed {
    logic              tv;
    logic              pol;
    logic [FIELDS-1:0] care;
    logic [FIELDS-1:0] val;
  } term_t;

  term_t shadow_q [TERMS];
  term_t active_q [TERMS];

  // ---------------------------------------------------------------------------
  // Cube tables
  // ---------------------------------------------------------------------------
  // NOTE: the tables are flops, not RAM, and they must read as all-invalid
  // immediately after reset, so they go in the async reset like any other
  // state. This is only valid because they are small.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < TERMS; t++) begin
        shadow_q[t] <= '0;
        active_q[t] <= '0;
      end
    end else begin
      // A commit copies the pre-edge shadow. A write in the same cycle lands
      // in the shadow afterwards and is therefore not part of this commit.
      if (cfg_commit) begin
        for (int t = 0; t < TERMS; t++) active_q[t] <= shadow_q[t];
      end
      if (cfg_we && (32'(cfg_addr) < TERMS)) begin
        shadow_q[cfg_addr] <= '{tv: cfg_tv, pol: cfg_pol, care: cfg_care, val: cfg_val};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic s1_valid, s2_valid;
  logic s1_adv, in_fire;

  assign s1_adv    = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s1_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: term match per lane, split by polarity
  // ---------------------------------------------------------------------------
  logic [TERMS-1:0] pos_m_d [LANES];
  logic [TERMS-1:0] neg_m_d [LANES];
  logic [LANES-1:0] en_d;

  // NOTE: every variable written here gets a default at the top of the block.
  // Without the default, a path that skips the assignment would infer a latch.
  // Blocking '=' is correct in combinational logic because 'hit' is a scratch
  // value that is consumed in the same pass.
  always_comb begin
    logic hit;
    hit  = 1'b0;
    en_d = '0;
    for (int l = 0; l < LANES; l++) begin
      pos_m_d[l] = '0;
      neg_m_d[l] = '0;
      en_d[l]    = in_data[EN_FIELD*LANES + l];
      for (int t = 0; t < TERMS; t++) begin
        hit = active_q[t].tv;
        for (int f = 0; f < FIELDS; f++) begin
          if (active_q[t].care[f] && (in_data[f*LANES + l] != active_q[t].val[f])) hit = 1'b0;
        end
        pos_m_d[l][t] = hit && !active_q[t].pol;
        neg_m_d[l][t] = hit &&  active_q[t].pol;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [TERMS-1:0] pos_m_q [LANES];
  logic [TERMS-1:0] neg_m_q [LANES];
  logic [LANES-1:0] en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      en_q     <= '0;
      for (int l = 0; l < LANES; l++) begin
        pos_m_q[l] <= '0;
        neg_m_q[l] <= '0;
      end
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        en_q     <= en_d;
        for (int l = 0; l < LANES; l++) begin
          pos_m_q[l] <= pos_m_d[l];
          neg_m_q[l] <= neg_m_d[l];
        end
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: OR-reduce and gate with the enable. Because the gates are
  // complementary, pos and neg of a lane can never both be set.
  // ---------------------------------------------------------------------------
  logic [2*LANES-1:0] z_d;

  always_comb begin
    z_d = '0;
    for (int l = 0; l < LANES; l++) begin
      z_d[l]         =  en_q[l] && (|pos_m_q[l]);
      z_d[LANES + l] = !en_q[l] && (|neg_m_q[l]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_z    <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        out_z    <= z_d;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

`ifdef PLA_SOP_STATS_EN
  // ---------------------------------------------------------------------------
  // Positive-hit handshake counter. Commit wins over a coincident count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else if (cfg_commit) begin
      stat_cnt <= '0;
    end else if (s2_valid && out_ready && (|out_z[LANES-1:0]) && (stat_cnt != 16'hFFFF)) begin
      stat_cnt <= stat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pla_sop_pipe.sv
// -----------------------------------------------------------------------------
// tb_pla_sop_pipe
//   Directed testbench for pla_sop_pipe with the default parameters
//   (8 lanes, 16 fields, 8 terms, enable field 5). Inputs are driven and
//   outputs are sampled on the falling edge of the clock.
// -----------------------------------------------------------------------------
module tb_pla_sop_pipe;

  localparam int LANES  = 8;
  localparam int FIELDS = 16;
  localparam int TERMS  = 8;
  localparam int DW     = LANES * FIELDS;
  localparam int AW     = $clog2(TERMS);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [2*LANES-1:0] out_z;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [FIELDS-1:0] cfg_care;
  logic [FIELDS-1:0] cfg_val;
  logic              cfg_pol;
  logic              cfg_tv;
  logic              cfg_commit;
`ifdef PLA_SOP_STATS_EN
  logic [15:0]       stat_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  pla_sop_pipe #(.LANES(LANES), .FIELDS(FIELDS), .TERMS(TERMS), .EN_FIELD(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_care   (cfg_care),
    .cfg_val    (cfg_val),
    .cfg_pol    (cfg_pol),
    .cfg_tv     (cfg_tv),
    .cfg_commit (cfg_commit)
`ifdef PLA_SOP_STATS_EN
    ,
    .stat_cnt   (stat_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Field-5 enable pattern p placed across the lanes.
  function automatic logic [DW-1:0] en_pat(input logic [7:0] p);
    logic [DW-1:0] d;
    d = '0;
    d[5*LANES +: LANES] = p;
    return d;
  endfunction

  // All of these tasks start and end at a falling edge.
  task automatic cfg_write(input int addr, input logic tv, input logic pol,
                           input logic [FIELDS-1:0] care, input logic [FIELDS-1:0] val);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_tv = tv; cfg_pol = pol;
    cfg_care = care; cfg_val = val;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  // Offer one sample and return at the falling edge after it was accepted.
  task automatic push(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("push_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Send a sample into an empty pipeline with out_ready high, and check the
  // 2-cycle latency and the result.
  task automatic single(input string tag, input logic [DW-1:0] d, input logic [15:0] exp);
    push(d);
    check({tag, "_lat"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(out_z), 32'(exp));
    @(negedge clk);
  endtask

  logic [DW-1:0] d;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_care = '0; cfg_val = '0;
    cfg_pol = 1'b0; cfg_tv = 1'b0; cfg_commit = 1'b0;

    // ---- Reset ----
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_z",     32'(out_z),     32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef PLA_SOP_STATS_EN
    check("rst_stat_cnt",  32'(stat_cnt),  32'h0);
`endif
    single("no_terms", '1, 16'h0000);

    // ---- Single term, default parameters ----
    cfg_write(0, 1'b1, 1'b0, 16'h0020, 16'h0020);
    commit();
    d = en_pat(8'h01);
    single("term0_pos", d, 16'h0001);
    cfg_write(0, 1'b1, 1'b1, 16'h0020, 16'h0000);
    commit();
    single("term0_neg", '0, 16'hFF00);

    // ---- Commit timing ----
    // The shadow is restored to the positive term. On the commit cycle term 1
    // (an always-matching negative term) is written, but it must be excluded.
    cfg_write(0, 1'b1, 1'b0, 16'h0020, 16'h0020);
    cfg_commit = 1'b1; cfg_we = 1'b1; cfg_addr = AW'(1); cfg_tv = 1'b1; cfg_pol = 1'b1;
    cfg_care = '0; cfg_val = '0;
    in_valid = 1'b1; in_data = '0;              // sample A, old table
    @(negedge clk);
    cfg_commit = 1'b0; cfg_we = 1'b0;
    check("commit_b_ready", 32'(in_ready), 32'd1);
    in_data = '0;                               // sample B, new table
    @(negedge clk);
    in_valid = 1'b0;
    check("commit_a_valid", 32'(out_valid), 32'd1);
    check("commit_a_old",   32'(out_z),     32'hFF00);
    @(negedge clk);
    check("commit_b_valid", 32'(out_valid), 32'd1);
    check("commit_b_new",   32'(out_z),     32'h0000);
    @(negedge clk);
    commit();                                   // now term 1 takes effect
    single("commit_term1", '0, 16'hFF00);

    // ---- Backpressure: out_z = {~p, p} for enable pattern p ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = en_pat(8'h01);
    @(negedge clk);
    check("bp_ready_1", 32'(in_ready), 32'd1);
    in_data = en_pat(8'h3C);
    @(negedge clk);
    check("bp_ready_full", 32'(in_ready), 32'd0);
    check("bp_valid",      32'(out_valid), 32'd1);
    check("bp_r0",         32'(out_z),     32'hFE01);
    in_data = en_pat(8'hA5);
    @(negedge clk);
    check("bp_hold_ready", 32'(in_ready),  32'd0);
    check("bp_hold_z1",    32'(out_z),     32'hFE01);
    @(negedge clk);
    check("bp_hold_z2",    32'(out_z),     32'hFE01);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1 check("bp_ready_comb", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp_r1", 32'(out_z), 32'hC33C);
    in_data = en_pat(8'hFF);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_r2", 32'(out_z), 32'h5AA5);
    @(negedge clk);
    check("bp_r3",       32'(out_z),     32'h00FF);
    check("bp_r3_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("bp_drained",  32'(out_valid), 32'd0);

    // ---- Multi-field cube: field0 = 1 and field1 = 0, enabled lanes ----
    cfg_write(0, 1'b0, 1'b0, '0, '0);
    cfg_write(1, 1'b0, 1'b0, '0, '0);
    cfg_write(2, 1'b1, 1'b0, 16'h0003, 16'h0001);
    commit();
    d = en_pat(8'hFF);
    d[7:0]  = 8'h0F;
    d[15:8] = 8'h05;
    single("multi_field", d, 16'h000A);

`ifdef PLA_SOP_STATS_EN
    // ---- Stats saturation and commit clear ----
    check("stat_one", 32'(stat_cnt), 32'd1);
    in_valid = 1'b1; in_data = d;
    repeat (70000) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("stat_sat", 32'(stat_cnt), 32'hFFFF);
    commit();
    check("stat_commit_clr", 32'(stat_cnt), 32'h0);
`endif

    // ---- Reset mid-stream with both stages full ----
    out_ready = 1'b0;
    push(en_pat(8'h01));
    push(en_pat(8'h3C));
    check("mid_full_ready", 32'(in_ready),  32'd0);
    check("mid_full_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_z",     32'(out_z),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_no_stale", 32'(out_valid), 32'd0);
    end
    single("mid_tables_clr", '1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pla_sop_pipe.md
# pla_sop_pipe

Pipelined, runtime-programmable sum-of-products evaluator for the multi-lane PLA decode family. Every lane is evaluated against one shared cube table. Each lane produces a complementary output pair:
- a positive output, gated by the lane's enable field;
- a negative output, gated by the inverse of the enable field.

The block succeeds the fixed combinational lane decoders and sits between the field-capture registers and the downstream decision logic. Lane count, field count and term count are parametrised. A valid/ready handshake with full backpressure is added.

## Interface
- LANES, 8, number of independent lanes.
- FIELDS, 16, input fields per lane.
- TERMS, 8, cube-table entries; must be ≥ 2.
- EN_FIELD, 5, field index used as the lane enable/polarity gate; must be < FIELDS.

Ports (AW = clog2(TERMS)):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- in_data  in  LANES*FIELDS  field f of lane l is at bit f*LANES+l.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_z  out  2*LANES  bit l = positive output of lane l; bit LANES+l = negative output of lane l.
- cfg_we  in  1  write one shadow-table entry.
- cfg_addr  in  AW  entry index; a value ≥ TERMS is ignored.
- cfg_care  in  FIELDS  care mask.
- cfg_val  in  FIELDS  required values.
- cfg_pol  in  1  0 = term feeds the positive OR; 1 = term feeds the negative OR.
- cfg_tv  in  1  term valid.
- cfg_commit  in  1  copy the shadow table to the active table.
- stat_cnt  out  16  present only with PLA_SOP_STATS_EN.

## Operation
- The shadow and active tables each hold TERMS entries of {tv, pol, care, val}. Reset clears both tables to all zero, so every term is invalid.
- **Term match for lane l, term t:** tv[t] & AND over f of (~care[t][f] | (field(l,f) == val[t][f])). The enable field may also appear in care.
- **Stage 1 (on accept):** per-lane match vectors are registered. The active table is sampled in this cycle only.
- **Stage 2:**
  - pos_l = en_l & OR(match[t] for terms with pol = 0)
  - neg_l = ~en_l & OR(match[t] for terms with pol = 1)
  - en_l = field(l, EN_FIELD), captured in stage 1.
  - Both results are registered into out_z.
- **Commit:** active ← shadow at the clock edge where cfg_commit = 1.
  - A sample accepted in the same cycle uses the old active table.
  - A cfg_we on the commit cycle writes the shadow and is not included in that commit.
  - Config writes are never blocked by pipeline state.
- **Flow control:**
  - s1 advances into s2 when !s2_valid | out_ready.
  - in_ready = !s1_valid | s1 advance.
  - No bubble insertion: one sample per cycle at full throughput.
- **Invariant:** pos_l and neg_l are never both 1.
- **Reset mid-operation:** both pipeline valids are cleared immediately. In-flight samples are discarded. Tables return to zero.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_z = 0, stat_cnt = 0.
- Latency: sample accepted at edge N → out_valid = 1 after edge N+1, i.e. 2 cycles.
- out_z and out_valid hold stable while out_valid & !out_ready.
- Back-to-back accepts with out_ready = 1 give one result per cycle, in order.
- When out_ready is low and both stages are full, in_ready = 0 combinationally in the same cycle.

## Configuration
- **PLA_SOP_STATS_EN defined:**
  - stat_cnt counts output handshakes (out_valid & out_ready) where any positive bit of out_z is set.
  - The count saturates at 0xFFFF.
  - It is cleared by reset and by cfg_commit. When commit and count coincide, the result is 0.
- **PLA_SOP_STATS_EN undefined:** the stat_cnt port and its counter are absent. All other behaviour is identical.

## Test plan
- **Reset:** drive rst_n low, then release → out_z = 0, out_valid = 0, in_ready = 1. A sample with all fields 1 yields out_z = 0, because no term is valid.
- **Single term, defaults:**
  - Program term 0 = {tv 1, pol 0, care bit 5, val bit 5 = 1} and commit.
  - Input with lane 0 field 5 = 1, all other bits 0 → 2 cycles later out_z = 0x0001.
  - Set term 0 to pol 1 with val bit 5 = 0 and commit.
  - Input with all zeros → out_z = 0xFF00.
- **Commit timing:** accept a sample on the cfg_commit cycle → old table result. The next sample → new table result.
- **Backpressure:** 4 samples, out_ready held low for 3 cycles → in_ready drops after 2 accepts. out_z holds stable. All 4 results emerge in order with none lost or duplicated.
- **Reset mid-stream:** pulse rst_n low with both stages full → out_valid = 0 on the following cycle. No stale result appears afterwards.
- **Stats (PLA_SOP_STATS_EN):**
  - 70000 positive-hit handshakes → stat_cnt = 0xFFFF.
  - A commit → stat_cnt = 0.
